// File: rtl/noc_outport_scheduler_if.sv
// noc_outport_scheduler_if
//   Handshake bundle between one output port's scheduler and its surroundings.
//   Flit type codes are defined here so every user of the bundle shares them.
//
//   req[4:0]        per-input flit-available request, bit order {S,W,E,N,L}
//   flit_id[14:0]   head flit type per input, 3 bits each, packed {S,W,E,N,L}
//   credit_in       one downstream credit returned this cycle
//   sel[5:0]        one-hot state: sel[5:1] = owner {S,W,E,N,L}, sel[0] = idle
//   grant[4:0]      pop strobe to the owner input's FIFO
//   xfer            flit valid towards downstream
//   credits         current credit count
//   err_credit      sticky credit-overflow flag
//   err_timeout     one-cycle pulse when the hold watchdog revokes a lock
//
//   master: drives req/flit_id/credit_in (input FIFOs, downstream link)
//   slave : the scheduler itself

`ifndef NOC_FLIT_DEFS
`define NOC_FLIT_DEFS
`define HEADER 3'd1
`define BODY   3'd2
`define TAIL   3'd3
`endif

interface noc_outport_scheduler_if #(
    parameter int unsigned CREDIT_W = 3
);
    logic [4:0]          req;
    logic [14:0]         flit_id;
    logic                credit_in;
    logic [5:0]          sel;
    logic [4:0]          grant;
    logic                xfer;
    logic [CREDIT_W-1:0] credits;
    logic                err_credit;
    logic                err_timeout;

    modport master (
        output req, flit_id, credit_in,
        input  sel, grant, xfer, credits, err_credit, err_timeout
    );

    modport slave (
        input  req, flit_id, credit_in,
        output sel, grant, xfer, credits, err_credit, err_timeout
    );
endinterface

// File: rtl/noc_outport_scheduler.sv
// noc_outport_scheduler
//   Per-output-port flit scheduler for a 5-port mesh router (L, N, E, W, S).
//   Locks one input from HEADER to TAIL, rotates priority round-robin with the
//   last-served input lowest, and gates every transfer on downstream credits.
//
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   noc_outport_scheduler_if.slave (req, flit_id, credit_in in;
//         sel, grant, xfer, credits, err_credit, err_timeout out)

module noc_outport_scheduler #(
    parameter int unsigned CREDIT_MAX = 4,
    parameter int unsigned CREDIT_W   = 3,
    parameter int unsigned HOLD_MAX   = 16
) (
    input logic                    clk,
    input logic                    rst,
    noc_outport_scheduler_if.slave bus
);

    localparam int unsigned HoldW = $clog2(HOLD_MAX + 1);

    // The state register is the one-hot sel output itself.
    typedef enum logic [5:0] {
        StIdle = 6'b000001,
        StL    = 6'b000010,
        StN    = 6'b000100,
        StE    = 6'b001000,
        StW    = 6'b010000,
        StS    = 6'b100000
    } sel_e;

    sel_e                sel_q, sel_d;
    logic [2:0]          rr_q, rr_d;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic                err_credit_q, err_credit_d;
    logic                err_timeout;

    logic [4:0] elig;
    logic [4:0] grant;
    logic       xfer;
    logic       credit_ok;
    logic       owner_req;
    logic [2:0] owner_flit;
    sel_e       win;

    // Round-robin pick: scan from ptr+1 upward, wrapping; walking from the
    // farthest candidate back lets the nearest eligible one win.
    function automatic sel_e rr_pick(input logic [4:0] el, input logic [2:0] ptr);
        sel_e       res;
        logic [2:0] idx;
        res = StIdle;
        for (int off = 5; off >= 1; off--) begin
            idx = 3'((int'(ptr) + off) % 5);
            if (el[idx]) begin
                res = sel_e'(6'b000010 << idx);
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] sel_idx(input sel_e s);
        logic [2:0] r;
        case (s)
            StL:     r = 3'd0;
            StN:     r = 3'd1;
            StE:     r = 3'd2;
            StW:     r = 3'd3;
            StS:     r = 3'd4;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        elig = '0;
        for (int i = 0; i < 5; i++) begin
            elig[i] = bus.req[i] & (bus.flit_id[3*i +: 3] == `HEADER);
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        owner_flit = '0;
        for (int i = 0; i < 5; i++) begin
            if (sel_q[i+1]) begin
                owner_req  = bus.req[i];
                owner_flit = bus.flit_id[3*i +: 3];
            end
        end
    end

    assign credit_ok = (credits_q != '0);
    assign grant     = sel_q[5:1] & bus.req & {5{credit_ok}};
    assign xfer      = |grant;

    // Next state, round-robin pointer and hold watchdog.
    always_comb begin
        sel_d       = sel_q;
        rr_d        = rr_q;
        hold_d      = hold_q;
        err_timeout = 1'b0;
        win         = StIdle;
        case (sel_q)
            StIdle: begin
                hold_d = '0;
                win    = rr_pick(elig, rr_q);
                sel_d  = win;
                if (win != StIdle) begin
                    rr_d = sel_idx(win);
                end
            end
            StL, StN, StE, StW, StS: begin
                if (xfer && owner_flit == `TAIL) begin
                    // Hand over in the TAIL cycle so the next packet follows with no bubble.
                    hold_d = '0;
                    win    = rr_pick(elig & ~sel_q[5:1], rr_q);
                    sel_d  = win;
                    if (win != StIdle) begin
                        rr_d = sel_idx(win);
                    end
                end else if (!owner_req) begin
                    if (hold_q == HoldW'(HOLD_MAX - 1)) begin
                        // Revoke the lock; pointer stays on the stalled owner.
                        sel_d       = StIdle;
                        hold_d      = '0;
                        err_timeout = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
                    hold_d = '0;
                end
            end
            default: begin
                sel_d  = StIdle;
                hold_d = '0;
            end
        endcase
    end

    // Credit counter; an overflowing return is dropped and flagged.
    always_comb begin
        credits_d    = credits_q;
        err_credit_d = err_credit_q;
        if (bus.credit_in && !xfer) begin
            if (credits_q == CREDIT_W'(CREDIT_MAX)) begin
                err_credit_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end else if (!bus.credit_in && xfer) begin
            credits_d = credits_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= StIdle;
            rr_q         <= 3'd4;
            hold_q       <= '0;
            credits_q    <= CREDIT_W'(CREDIT_MAX);
            err_credit_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            rr_q         <= rr_d;
            hold_q       <= hold_d;
            credits_q    <= credits_d;
            err_credit_q <= err_credit_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.grant       = grant;
    assign bus.xfer        = xfer;
    assign bus.credits     = credits_q;
    assign bus.err_credit  = err_credit_q;
    assign bus.err_timeout = err_timeout;

endmodule

// File: tb/tb_noc_outport_scheduler.sv
// Bench for noc_outport_scheduler: per-input flit queues feed the DUT, a
// behavioural model predicts every cycle, and a monitor checks each transfer
// against a scoreboard of predicted transfers.

`ifndef NOC_FLIT_DEFS
`define NOC_FLIT_DEFS
`define HEADER 3'd1
`define BODY   3'd2
`define TAIL   3'd3
`endif

module tb_noc_outport_scheduler;

    localparam int CMAX = 4;
    localparam int HOLD = 16;
    localparam int FH   = 1;
    localparam int FB   = 2;
    localparam int FT   = 3;

    logic clk;
    logic rst;

    noc_outport_scheduler_if #(.CREDIT_W(3)) bus ();

    noc_outport_scheduler #(
        .CREDIT_MAX(CMAX),
        .CREDIT_W  (3),
        .HOLD_MAX  (HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass;
    int n_chk;
    int fq [5][$];        // per-input flit queue: (seq << 2) | type
    int sb_idx [$];
    int sb_tag [$];
    int seq;
    int m_owner, m_ptr, m_cred, m_hold;
    bit m_err;
    bit [4:0] gate;
    int stall [5];
    bit rnd_req;
    int cin_mode;
    int to_seen;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_pkt(input int i, input int len);
        for (int k = 0; k < len; k++) begin
            int t;
            t = (k == 0) ? FH : ((k == len - 1) ? FT : FB);
            seq++;
            fq[i].push_back((seq << 2) | t);
        end
    endtask

    function automatic int in_type(input int i);
        logic [14:0] f;
        f = bus.flit_id;
        return int'(f[3*i +: 3]);
    endfunction

    function automatic bit is_elig(input int i);
        return bus.req[i] && in_type(i) == FH;
    endfunction

    // Next owner: first eligible input after the pointer, skipping excl.
    function automatic int pick(input int excl);
        for (int s = 1; s <= 5; s++) begin
            int i;
            i = (m_ptr + s) % 5;
            if (i != excl && is_elig(i)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 4;
        m_cred  = CMAX;
        m_hold  = 0;
        m_err   = 1'b0;
    endtask

    task automatic drive();
        logic [4:0]  r;
        logic [14:0] f;
        r = '0;
        f = '0;
        for (int i = 0; i < 5; i++) begin
            int ft;
            if (rnd_req && fq[i].size() == 0 && ($urandom % 4) == 0) begin
                push_pkt(i, 2 + int'($urandom % 4));
            end
            if (rnd_req) begin
                if (stall[i] > 0) stall[i]--;
                else if (($urandom % 150) == 0) stall[i] = 20;
            end
            r[i] = (fq[i].size() > 0) && !gate[i] && stall[i] == 0
                   && (!rnd_req || ($urandom % 5) != 0);
            ft = (fq[i].size() > 0) ? (fq[i][0] & 3) : FB;
            f[3*i +: 3] = 3'(ft);
        end
        bus.req     = r;
        bus.flit_id = f;
        case (cin_mode)
            1:       bus.credit_in = (m_cred < CMAX) && (($urandom % 3) == 0);
            2: begin
                bus.credit_in = 1'b1;
                cin_mode      = 0;
            end
            default: bus.credit_in = 1'b0;
        endcase
    endtask

    // One clock cycle: check DUT against the model, advance the model, then
    // pop granted flits and drive the next inputs.
    task automatic step();
        int         eg;
        int         exp_sel;
        int         w;
        bit         eto;
        logic [4:0] g_dut;
        bit         to_dut;
        @(negedge clk);
        eg      = (m_owner >= 0 && bus.req[m_owner] && m_cred > 0) ? (1 << m_owner) : 0;
        eto     = (m_owner >= 0 && !bus.req[m_owner] && m_hold + 1 == HOLD);
        exp_sel = (m_owner < 0) ? 1 : (2 << m_owner);
        chk("sel", int'(bus.sel), exp_sel);
        chk("grant", int'(bus.grant), eg);
        chk("xfer", int'(bus.xfer), int'(eg != 0));
        chk("credits", int'(bus.credits), m_cred);
        chk("err_credit", int'(bus.err_credit), int'(m_err));
        chk("err_timeout", int'(bus.err_timeout), int'(eto));
        if (eg != 0) begin
            sb_idx.push_back(m_owner);
            sb_tag.push_back(fq[m_owner].size() > 0 ? (fq[m_owner][0] >> 2) : -1);
        end
        if (m_owner < 0) begin
            w = pick(-1);
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = w;
            end
            m_hold = 0;
        end else if (eg != 0 && in_type(m_owner) == FT) begin
            w       = pick(m_owner);
            m_owner = w;
            if (w >= 0) m_ptr = w;
            m_hold = 0;
        end else if (!bus.req[m_owner]) begin
            if (eto) begin
                m_owner = -1;
                m_hold  = 0;
            end else begin
                m_hold++;
            end
        end else begin
            m_hold = 0;
        end
        if (bus.credit_in && eg == 0 && m_cred == CMAX) m_err = 1'b1;
        else m_cred = m_cred + int'(bus.credit_in) - int'(eg != 0);
        g_dut  = bus.grant;
        to_dut = bus.err_timeout;
        if (to_dut) to_seen++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (g_dut[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            if (to_dut) begin
                while (fq[i].size() > 0 && (fq[i][0] & 3) != FH) void'(fq[i].pop_front());
            end
        end
        drive();
    endtask

    task automatic clear_all();
        for (int i = 0; i < 5; i++) begin
            fq[i].delete();
            stall[i] = 0;
        end
        sb_idx.delete();
        sb_tag.delete();
        gate          = '0;
        cin_mode      = 0;
        bus.req       = '0;
        bus.flit_id   = '0;
        bus.credit_in = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        clear_all();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    // Scoreboard monitor: every DUT transfer must match the oldest prediction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.xfer === 1'b1) begin
                int gi;
                int got_tag;
                gi = -1;
                for (int i = 0; i < 5; i++) if (bus.grant[i]) gi = i;
                chk("sb_nonempty", int'(sb_idx.size() > 0), 1);
                if (sb_idx.size() > 0) begin
                    got_tag = (gi >= 0 && fq[gi].size() > 0) ? (fq[gi][0] >> 2) : -1;
                    chk("sb_port", gi, sb_idx.pop_front());
                    chk("sb_flit", got_tag, sb_tag.pop_front());
                end
            end
        end
    end

    initial begin
        bit reached;
        n_pass  = 0;
        n_chk   = 0;
        seq     = 0;
        rnd_req = 1'b0;
        to_seen = 0;
        rst     = 1'b1;
        clear_all();
        model_reset();
        #12;
        chk("rst_sel", int'(bus.sel), 1);
        chk("rst_credits", int'(bus.credits), CMAX);
        chk("rst_err_credit", int'(bus.err_credit), 0);
        chk("rst_err_timeout", int'(bus.err_timeout), 0);
        chk("rst_grant", int'(bus.grant), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single L packet H,B,B,T with no credit return: credits drain to 0.
        push_pkt(0, 4);
        drive();
        repeat (7) step();

        // Credit stall on L, one returned credit releases exactly one flit.
        push_pkt(0, 4);
        repeat (4) step();
        cin_mode = 2;
        repeat (6) step();
        cin_mode = 1;
        repeat (30) step();

        // N and E headers together from reset; a second N packet waits for E.
        do_reset();
        push_pkt(1, 3);
        push_pkt(2, 3);
        push_pkt(1, 3);
        cin_mode = 1;
        repeat (40) step();

        // W stalls mid-packet until the watchdog revokes; waiting S then wins.
        gate = 5'b10000;
        push_pkt(3, 4);
        push_pkt(4, 3);
        reached = 1'b0;
        for (int k = 0; k < 60 && !reached; k++) begin
            step();
            reached = (m_owner == 3 && fq[3].size() < 4);
        end
        chk("w_locked", int'(reached), 1);
        gate    = 5'b01000;
        to_seen = 0;
        repeat (24) step();
        chk("timeout_pulses", to_seen, 1);
        gate = '0;
        repeat (30) step();

        // Credit overflow at full count is sticky.
        reached = 1'b0;
        for (int k = 0; k < 200 && !reached; k++) begin
            step();
            reached = (m_cred == CMAX && m_owner < 0 && sb_idx.size() == 0);
        end
        chk("credits_full", int'(reached), 1);
        cin_mode = 2;
        repeat (6) step();
        chk("err_credit_sticky", int'(bus.err_credit), 1);

        // Async reset in the middle of an E packet with two credits left.
        push_pkt(2, 5);
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            step();
            reached = (m_owner == 2 && m_cred == 2);
        end
        chk("e_mid_packet", int'(reached), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sel", int'(bus.sel), 1);
        chk("arst_credits", int'(bus.credits), CMAX);
        chk("arst_grant", int'(bus.grant), 0);
        chk("arst_err_credit", int'(bus.err_credit), 0);
        clear_all();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        repeat (3) step();

        // Randomised traffic, credit returns and stalls.
        rnd_req  = 1'b1;
        cin_mode = 1;
        repeat (3000) step();
        rnd_req = 1'b0;
        gate    = 5'b11111;
        repeat (3) step();
        chk("sb_drained", sb_idx.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/noc_outport_scheduler.md
Name: noc_outport_scheduler

Overview:
- Per-output-port flit scheduler for the 5-port mesh router (ports L, N, E, W, S).
- Grants one input packet at a time and holds the grant from HEADER to TAIL.
- Rotates priority round-robin; the last-served input gets lowest priority.
- Gates every flit transfer on downstream credits. One instance sits beside each output port's crossbar mux and drives its select and the input FIFO pop strobes.

Parameters:
- CREDIT_MAX, 4, downstream buffer depth in flits; reset value of the credit counter.
- CREDIT_W, 3, credit counter width; must satisfy 2^CREDIT_W > CREDIT_MAX.
- HOLD_MAX, 16, consecutive cycles an owner may leave req low mid-packet before its lock is revoked.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  5  per-input flit-available request, bit order {S,W,E,N,L}; L is bit 0.
- flit_id  in  15  per-input flit type of the head flit, 3 bits per input, packed {S,W,E,N,L}, coded with `HEADER / `BODY / `TAIL.
- credit_in  in  1  one credit returned by downstream this cycle.
- sel  out  6  registered one-hot state: sel[5:1] = owner {S,W,E,N,L}, sel[0] = idle.
- grant  out  5  combinational pop strobe to the owner input's FIFO; the flit crosses this cycle.
- xfer  out  1  OR of grant; valid strobe to downstream.
- credits  out  CREDIT_W  current credit count.
- err_credit  out  1  sticky; set on credit overflow.
- err_timeout  out  1  one-cycle pulse when a lock is revoked by the hold watchdog.

Behaviour:
- Reset (asynchronous, immediate, also mid-packet):
  - sel = 6'b000001, credits = CREDIT_MAX, err_credit = 0, err_timeout = 0, hold counter = 0.
  - Round-robin pointer = S, so L has highest priority on the first arbitration.
- Grant:
  - grant[i] = sel[i+1] & req[i] & (credits != 0).
  - xfer = |grant. There is no other transfer path.
- Credits:
  - next = credits - xfer + credit_in.
  - A credit_in arriving in the same cycle as credits==0 does not enable a transfer until the next cycle.
  - If credits==CREDIT_MAX, credit_in=1 and xfer=0: the count holds and err_credit sets. It clears only on rst.
- Arbitration eligibility: input i is eligible when req[i]=1 and its flit_id==`HEADER. Inputs presenting non-HEADER flits are never granted a new lock.
- Priority:
  - Search order starts at the input after the round-robin pointer: L→N→E→W→S, wrapping.
  - The pointer updates to the new owner whenever a lock is taken.
- IDLE state (sel[0]=1):
  - If any input is eligible, the winner becomes the owner the next cycle. There is a 1-cycle allocation latency; the first flit crosses no earlier than the cycle after the request.
  - If no input is eligible, stay in IDLE.
- LOCKED state (owner k):
  - Lock is held across BODY flits and credit stalls.
  - When a grant[k] cycle carries flit_id==`TAIL, re-arbitrate in that same cycle among eligible inputs excluding k. The next state is the winner, or IDLE if none. This gives back-to-back packets with no idle bubble.
  - A `HEADER flit on the owner while locked is a protocol error. It is transferred as a normal flit and the lock is held.
- Hold watchdog:
  - The counter increments each LOCKED cycle with req[k]=0.
  - It clears on any cycle with req[k]=1 or on lock change. Credit-starved cycles with req[k]=1 do not count.
  - When the counter reaches HOLD_MAX: next state IDLE, err_timeout pulses for one cycle, counter clears, and the pointer stays at k.
- Minimum packet length is 2 flits (HEADER…TAIL). Single-flit packets are not supported.
- sel never has more than one bit set. An illegal encoding decodes to IDLE the next cycle.

Test Plan:
- Reset, then req=5'b00001 with L=`HEADER, holding L flits H,B,B,T and no credit_in (CREDIT_MAX=4) → sel=000010 at cycle 1; grant=00001 at cycles 1-4; credits 4→0; sel=000001 at cycle 5.
- N and E request headers simultaneously from IDLE, pointer=S → N wins (sel=000100). After N's TAIL, E is granted in the next cycle with no IDLE gap. A new N header during E's packet waits until E's TAIL.
- Credits=0 while owner L holds BODY with req=1 → grant=0 and sel held. Pulse credit_in → grant=00001 exactly the following cycle, credits 1→0.
- Owner W drops req mid-packet for HOLD_MAX=16 cycles → err_timeout=1 for one cycle at the 16th cycle, sel=000001 next. A waiting S header is then granted.
- credit_in=1 with credits=4 and no xfer → credits stays 4, err_credit=1 and stays set until rst.
- Assert rst asynchronously mid-packet (owner E, credits=2) → sel=000001, credits=4, grant=0 immediately, without waiting for a clock edge.
